usb_packet_tx: RTL

USB_PACKET_TX -- requirements
Module: usb_packet_tx

---
 rtl/usb_packet_tx_if.sv | 35 +++
 rtl/usb_packet_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/usb_packet_tx_if.sv
// PID type shared by the packet transmitter and its users, plus the bundle of
// payload, packet-request and PHY-side signals used as the transmitter's port.
package usb_packet_tx_pkg;
  typedef enum logic [3:0] {
    PID_RSVD  = 4'h0, PID_OUT   = 4'h1, PID_ACK   = 4'h2, PID_DATA0 = 4'h3,
    PID_PING  = 4'h4, PID_SOF   = 4'h5, PID_NYET  = 4'h6, PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8, PID_IN    = 4'h9, PID_NAK   = 4'hA, PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC, PID_SETUP = 4'hD, PID_STALL = 4'hE, PID_MDATA = 4'hF
  } pid_t;
endpackage

interface usb_packet_tx_if;
  import usb_packet_tx_pkg::*;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       send;
  pid_t       pid;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  wr_en, wr_data, send, pid, tx_ready,
    output busy, done, err, tx_data, tx_valid
  );

  modport master (
    output wr_en, wr_data, send, pid, tx_ready,
    input  busy, done, err, tx_data, tx_valid
  );
endinterface

// File: rtl/usb_packet_tx.sv
// USB packet transmitter: buffers up to 8 payload bytes and emits handshake or
// DATA0/DATA1 packets byte by byte to the PHY, appending the inverted CRC16.
module usb_packet_tx
  import usb_packet_tx_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  usb_packet_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  buf_q [8];
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        err_q, err_d;
  logic        is_data_q, is_data_d;
  logic        buf_we;
  logic        take;
  logic        pid_hs, pid_dat;
  logic [3:0]  pid_raw;
  logic [7:0]  rd_byte;

  // LSB-first CRC16 (x^16+x^15+x^2+1) advanced by one whole byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign pid_raw = bus.pid;
  assign pid_hs  = (bus.pid == PID_ACK) || (bus.pid == PID_NAK) || (bus.pid == PID_STALL);
  assign pid_dat = (bus.pid == PID_DATA0) || (bus.pid == PID_DATA1);
  assign take    = tx_valid_q & bus.tx_ready;
  assign rd_byte = buf_q[idx_q[2:0]];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    is_data_d  = is_data_q;
    buf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          if (pid_hs || pid_dat) begin
            state_d    = S_PID;
            tx_data_d  = {~pid_raw, pid_raw};
            tx_valid_d = 1'b1;
            crc_d      = 16'hFFFF;
            idx_d      = 4'd0;
            is_data_d  = pid_dat;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.wr_en && (len_q != 4'd8)) begin
          buf_we = 1'b1;
          len_d  = len_q + 4'd1;
        end
      end
      S_PID: begin
        if (take) begin
          if (!is_data_q) begin
            state_d    = S_EOP;
            tx_valid_d = 1'b0;
            len_d      = 4'd0;
          end else if (len_q == 4'd0) begin
            state_d   = S_CRC_LO;
            tx_data_d = ~crc_q[7:0];
          end else begin
            state_d   = S_DATA;
            tx_data_d = rd_byte;
            crc_d     = crc16_byte(crc_q, rd_byte);
            idx_d     = idx_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        // The CRC absorbs each byte as it is loaded, so it is final by CRC_LO.
        if (take) begin
          if (idx_q == len_q) begin
            state_d   = S_CRC_LO;
            tx_data_d = ~crc_q[7:0];
          end else begin
            tx_data_d = rd_byte;
            crc_d     = crc16_byte(crc_q, rd_byte);
            idx_d     = idx_q + 4'd1;
          end
        end
      end
      S_CRC_LO: begin
        if (take) begin
          state_d   = S_CRC_HI;
          tx_data_d = ~crc_q[15:8];
        end
      end
      S_CRC_HI: begin
        if (take) begin
          state_d    = S_EOP;
          tx_valid_d = 1'b0;
          len_d      = 4'd0;
        end
      end
      S_EOP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= 4'd0;
      idx_q      <= 4'd0;
      crc_q      <= 16'hFFFF;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      is_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      is_data_q  <= is_data_d;
    end
  end

  // NOTE: the payload memory has no reset; length gates which entries are ever read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[len_q[2:0]] <= bus.wr_data;
    end
  end

  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_EOP);
  assign bus.done     = (state_q == S_EOP);
  assign bus.err      = err_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

endmodule
